// File: rtl/qdec_cabac_package.sv
// Shared CABAC definitions: chroma-QP-offset encode FSM states and the
// context indices used by both the decode and encode directions.
package qdec_cabac_package;

    typedef enum logic [1:0] {
        IDLE_CQPE   = 2'd0,
        FLAG_CQPE   = 2'd1,
        IDX_CQPE    = 2'd2,
        ENDING_CQPE = 2'd3
    } t_state_cqp_enc;

    localparam logic [9:0] CTXIDX_CHROMA_QP_OFFSET_FLAG = 10'd160;
    localparam logic [9:0] CTXIDX_CHROMA_QP_OFFSET_IDX  = 10'd161;

endpackage : qdec_cabac_package

// File: rtl/qenc_cqp_bin_fsm.sv
// Binarizes cu_chroma_qp_offset_flag/idx (TR, cRiceParam=0) into context-coded bins.
// Optional QENC_CQP_IDX_CHECK_EN clamps an out-of-range idx and pulses cqp_err.
module qenc_cqp_bin_fsm
    import qdec_cabac_package::*;
#(
    parameter int CTX_ADDR_W = 10,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cqp_start,
    input  logic                  cu_chroma_qp_offset_enabled_flag,
    input  logic                  cu_chroma_qp_offset_flag,
    input  logic [IDX_W-1:0]      cu_chroma_qp_offset_idx,
    input  logic [IDX_W-1:0]      chroma_qp_offset_list_len_minus1,
    output logic [CTX_ADDR_W-1:0] ctx_cqp_addr,
    output logic                  enc_bin,
    output logic                  enc_bin_vld,
    input  logic                  enc_rdy,
    output logic                  EPMode_cqp,
    output logic                  cqp_done_intr,
    output logic                  cqp_err
);

    t_state_cqp_enc          state_q, state_d;
    logic                    flag_q, flag_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        len_q, len_d;
    logic [IDX_W-1:0]        bin_cnt_q, bin_cnt_d;
    logic                    err_d;

    logic [CTX_ADDR_W-1:0]   ctx_q, ctx_d;
    logic                    bin_q, bin_d;
    logic                    vld_q, vld_d;
    logic                    done_q, done_d;
    logic                    err_q;

    logic [IDX_W-1:0]        idx_in_s;
    logic                    idx_err_s;
    logic                    last_idx_bin_s;

    // Start-time index conditioning: clamp and range error only with the check enabled
    always_comb begin
`ifdef QENC_CQP_IDX_CHECK_EN
        if (cu_chroma_qp_offset_idx > chroma_qp_offset_list_len_minus1) begin
            idx_in_s  = chroma_qp_offset_list_len_minus1;
            idx_err_s = cu_chroma_qp_offset_enabled_flag & cu_chroma_qp_offset_flag;
        end else begin
            idx_in_s  = cu_chroma_qp_offset_idx;
            idx_err_s = 1'b0;
        end
`else
        idx_in_s  = cu_chroma_qp_offset_idx;
        idx_err_s = 1'b0;
`endif
    end

    // TR ends with the terminating 0 at bin idx, or at cMax-1 when idx reaches cMax
    assign last_idx_bin_s = (bin_cnt_q == idx_q) || (bin_cnt_q == (len_q - {{(IDX_W-1){1'b0}}, 1'b1}));

    // State and latched-field register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE_CQPE;
            flag_q    <= 1'b0;
            idx_q     <= '0;
            len_q     <= '0;
            bin_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            bin_cnt_q <= bin_cnt_d;
        end
    end

    // Next-state and field update
    always_comb begin
        state_d   = state_q;
        flag_d    = flag_q;
        idx_d     = idx_q;
        len_d     = len_q;
        bin_cnt_d = bin_cnt_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE_CQPE: begin
                if (cqp_start) begin
                    flag_d    = cu_chroma_qp_offset_flag;
                    idx_d     = idx_in_s;
                    len_d     = chroma_qp_offset_list_len_minus1;
                    bin_cnt_d = '0;
                    err_d     = idx_err_s;
                    state_d   = cu_chroma_qp_offset_enabled_flag ? FLAG_CQPE : ENDING_CQPE;
                end else begin
                    state_d   = IDLE_CQPE;
                end
            end
            FLAG_CQPE: begin
                if (enc_rdy) begin
                    state_d = (flag_q && (len_q != '0)) ? IDX_CQPE : ENDING_CQPE;
                end else begin
                    state_d = FLAG_CQPE;
                end
            end
            IDX_CQPE: begin
                if (enc_rdy && last_idx_bin_s) begin
                    state_d = ENDING_CQPE;
                end else if (enc_rdy) begin
                    bin_cnt_d = bin_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDX_CQPE;
                end
            end
            ENDING_CQPE: begin
                state_d = IDLE_CQPE;
            end
            default: begin
                state_d = IDLE_CQPE;
            end
        endcase
    end

    // Output decode of the upcoming state so bins appear the cycle the state is entered
    always_comb begin
        ctx_d  = '0;
        bin_d  = 1'b0;
        vld_d  = 1'b0;
        done_d = 1'b0;
        case (state_d)
            FLAG_CQPE: begin
                vld_d = 1'b1;
                bin_d = flag_d;
                ctx_d = CTX_ADDR_W'(CTXIDX_CHROMA_QP_OFFSET_FLAG);
            end
            IDX_CQPE: begin
                vld_d = 1'b1;
                bin_d = (bin_cnt_d < idx_d);
                ctx_d = CTX_ADDR_W'(CTXIDX_CHROMA_QP_OFFSET_IDX);
            end
            ENDING_CQPE: begin
                done_d = 1'b1;
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_q  <= '0;
            bin_q  <= 1'b0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ctx_q  <= ctx_d;
            bin_q  <= bin_d;
            vld_q  <= vld_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign ctx_cqp_addr  = ctx_q;
    assign enc_bin       = bin_q;
    assign enc_bin_vld   = vld_q;
    assign cqp_done_intr = done_q;
    assign cqp_err       = err_q;
    assign EPMode_cqp    = 1'b0;

endmodule : qenc_cqp_bin_fsm

// File: tb/tb_qenc_cqp_bin_fsm.sv
// Directed self-checking bench for qenc_cqp_bin_fsm (default or QENC_CQP_IDX_CHECK_EN build).
module tb_qenc_cqp_bin_fsm;
    import qdec_cabac_package::*;

    localparam logic [9:0] CF = CTXIDX_CHROMA_QP_OFFSET_FLAG;
    localparam logic [9:0] CI = CTXIDX_CHROMA_QP_OFFSET_IDX;
`ifdef QENC_CQP_IDX_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       cqp_start;
    logic       en;
    logic       flag;
    logic [2:0] idx;
    logic [2:0] len;
    logic [9:0] ctx;
    logic       bin;
    logic       vld;
    logic       rdy;
    logic       ep;
    logic       done;
    logic       err;

    int checks;
    int errors;

    qenc_cqp_bin_fsm #(.CTX_ADDR_W(10), .IDX_W(3)) dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .cqp_start                        (cqp_start),
        .cu_chroma_qp_offset_enabled_flag (en),
        .cu_chroma_qp_offset_flag         (flag),
        .cu_chroma_qp_offset_idx          (idx),
        .chroma_qp_offset_list_len_minus1 (len),
        .ctx_cqp_addr                     (ctx),
        .enc_bin                          (bin),
        .enc_bin_vld                      (vld),
        .enc_rdy                          (rdy),
        .EPMode_cqp                       (ep),
        .cqp_done_intr                    (done),
        .cqp_err                          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bin(input string tag, input logic b, input logic [9:0] c);
        chk_eq({tag, ".vld"},  {31'd0, vld},  32'd1);
        chk_eq({tag, ".bin"},  {31'd0, bin},  {31'd0, b});
        chk_eq({tag, ".ctx"},  {22'd0, ctx},  {22'd0, c});
        chk_eq({tag, ".done"}, {31'd0, done}, 32'd0);
        chk_eq({tag, ".ep"},   {31'd0, ep},   32'd0);
    endtask

    task automatic expect_done(input string tag);
        chk_eq({tag, ".vld"},  {31'd0, vld},  32'd0);
        chk_eq({tag, ".done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic expect_quiet(input string tag);
        chk_eq({tag, ".vld"},  {31'd0, vld},  32'd0);
        chk_eq({tag, ".done"}, {31'd0, done}, 32'd0);
        chk_eq({tag, ".bin"},  {31'd0, bin},  32'd0);
        chk_eq({tag, ".ctx"},  {22'd0, ctx},  32'd0);
    endtask

    // Drive a start in the current cycle; returns in cycle 1 with start dropped
    task automatic start(input logic e, input logic f, input logic [2:0] i, input logic [2:0] l);
        en = e; flag = f; idx = i; len = l;
        cqp_start = 1'b1;
        step();
        cqp_start = 1'b0;
    endtask

    logic       exp_bins [4];
    logic [9:0] exp_ctxs [4];

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; cqp_start = 1'b0; en = 1'b0; flag = 1'b0;
        idx = 3'd0; len = 3'd0; rdy = 1'b1;
        #12;
        expect_quiet("reset");
        chk_eq("reset.err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        step();

        // enable=0: done in cycle 1 only; start during ENDING ignored; back-to-back start
        start(1'b0, 1'b1, 3'd1, 3'd4);
        expect_done("dis.c1");
        cqp_start = 1'b1; en = 1'b1; flag = 1'b1;
        step();
        cqp_start = 1'b0;
        expect_quiet("dis.c2");
        start(1'b1, 1'b0, 3'd0, 3'd4);
        expect_bin("b2b.c1", 1'b0, CF);
        step();
        expect_done("b2b.c2");
        step();
        expect_quiet("b2b.c3");

        // flag=1 idx=2 len=4: 1 | 1 1 0
        start(1'b1, 1'b1, 3'd2, 3'd4);
        expect_bin("i2.c1", 1'b1, CF);
        step(); expect_bin("i2.c2", 1'b1, CI);
        step(); expect_bin("i2.c3", 1'b1, CI);
        step(); expect_bin("i2.c4", 1'b0, CI);
        step(); expect_done("i2.c5");
        step(); expect_quiet("i2.c6");

        // idx=cMax=3 with enc_rdy 1-of-3, plus ignored start during stalls
        exp_bins = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_ctxs = '{CF, CI, CI, CI};
        rdy = 1'b0;
        start(1'b1, 1'b1, 3'd3, 3'd3);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                expect_bin($sformatf("stall.b%0d.k%0d", b, k), exp_bins[b], exp_ctxs[b]);
                rdy = (k == 2);
                cqp_start = (k == 0);
                en = 1'b1; flag = 1'b0; idx = 3'd0; len = 3'd0;
                step();
                cqp_start = 1'b0;
            end
        end
        rdy = 1'b1;
        expect_done("stall.done");
        step(); expect_quiet("stall.idle");

        // len_minus1=0: flag bin only
        start(1'b1, 1'b1, 3'd0, 3'd0);
        expect_bin("l0.c1", 1'b1, CF);
        step(); expect_done("l0.c2");
        step();

        // reset in the middle of IDX
        start(1'b1, 1'b1, 3'd2, 3'd4);
        step();
        expect_bin("rst.c2", 1'b1, CI);
        rst_n = 1'b0;
        #1;
        expect_quiet("rst.async");
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            expect_quiet($sformatf("rst.after%0d", c));
        end

        // idx=7 beyond cMax=2: bins bounded to cMax, err only with the check build
        start(1'b1, 1'b1, 3'd7, 3'd2);
        expect_bin("ovr.c1", 1'b1, CF);
        chk_eq("ovr.err1", {31'd0, err}, {31'd0, EXP_ERR});
        step(); expect_bin("ovr.c2", 1'b1, CI);
        chk_eq("ovr.err2", {31'd0, err}, 32'd0);
        step(); expect_bin("ovr.c3", 1'b1, CI);
        step(); expect_done("ovr.c4");
        step(); expect_quiet("ovr.c5");

        // flag=0 with idx out of range never reports an error
        start(1'b1, 1'b0, 3'd7, 3'd2);
        expect_bin("nf.c1", 1'b0, CF);
        chk_eq("nf.err", {31'd0, err}, 32'd0);
        step(); expect_done("nf.c2");
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_qenc_cqp_bin_fsm
